// File: rtl/genesis_pad_responder_if.sv
// Pad bus between a Genesis/Master System console (master) and the pad responder (slave).
//   iSELECT     : console SELECT/TH line, asynchronous to the responder clock, idle high
//   iBUTTONS    : {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed
//   iSIX_BUTTON : 1 = 6-button protocol, 0 = 3-button protocol
//   oPAD        : {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active-low
//   oPHASE      : current phase counter (debug)
interface genesis_pad_responder_if;
  logic        iSELECT;
  logic [11:0] iBUTTONS;
  logic        iSIX_BUTTON;
  logic [5:0]  oPAD;
  logic [2:0]  oPHASE;

  modport master (
    output iSELECT,
    output iBUTTONS,
    output iSIX_BUTTON,
    input  oPAD,
    input  oPHASE
  );

  modport slave (
    input  iSELECT,
    input  iBUTTONS,
    input  iSIX_BUTTON,
    output oPAD,
    output oPHASE
  );
endinterface

// File: rtl/genesis_pad_responder.sv
// Device-side Genesis/Master System gamepad emulator. Tracks the console's SELECT line,
// counts SELECT edges into a 3-bit phase, and drives the six active-low pad lines with the
// 3-button or 6-button multiplexed button pattern for that phase.
//   TIMEOUT  : SELECT idle cycles before the phase counter falls back to its start
//   iCLK     : system clock
//   iN_RESET : synchronous active-low reset
//   bus      : pad bus (slave side), see genesis_pad_responder_if
module genesis_pad_responder #(
  parameter int unsigned TIMEOUT = 75000
) (
  input logic                     iCLK,
  input logic                     iN_RESET,
  genesis_pad_responder_if.slave  bus
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [2:0]       phase_q, phase_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [5:0]       pad_q, pad_d;
  logic             sel_edge;

  logic btn_z, btn_y, btn_x, btn_m, btn_s, btn_c, btn_b, btn_a, btn_u, btn_d, btn_l, btn_r;
  logic [5:0] pad_hi, pad_lo, pad_id, pad_ext, pad_p7;

  assign {btn_z, btn_y, btn_x, btn_m, btn_s, btn_c,
          btn_b, btn_a, btn_u, btn_d, btn_l, btn_r} = bus.iBUTTONS;

  // Candidate line patterns; forced-low/high lines are literal, the rest are inverted presses.
  assign pad_hi  = ~{btn_c, btn_b, btn_u, btn_d, btn_l, btn_r};
  assign pad_lo  = {~btn_s, ~btn_a, ~btn_u, ~btn_d, 2'b00};
  assign pad_id  = {~btn_s, ~btn_a, 4'b0000};
  assign pad_ext = ~{btn_c, btn_b, btn_z, btn_y, btn_x, btn_m};
  assign pad_p7  = {~btn_s, ~btn_a, 4'b1111};

  always_comb begin
    s1_d     = bus.iSELECT;
    s2_d     = s1_q;
    s3_d     = s2_q;
    sel_edge = s2_q ^ s3_q;
    phase_d  = phase_q;
    idle_d   = idle_q;

    // An edge beats the timeout when both land in the same cycle.
    if (sel_edge) begin
      idle_d  = '0;
      phase_d = phase_q + 3'd1;
    end else if (idle_q != IdleW'(TIMEOUT)) begin
      idle_d = idle_q + IdleW'(1);
    end else begin
      phase_d = {2'b00, ~s2_q};
    end

    // Mapping uses the next phase so the lines change on the same edge as oPHASE.
    if (bus.iSIX_BUTTON) begin
      pad_d = pad_hi;
      case (phase_d)
        3'd1, 3'd3: pad_d = pad_lo;
        3'd5:       pad_d = pad_id;
        3'd6:       pad_d = pad_ext;
        3'd7:       pad_d = pad_p7;
        default:    pad_d = pad_hi;
      endcase
    end else begin
      pad_d = s2_q ? pad_hi : pad_lo;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iN_RESET) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      phase_q <= 3'd0;
      idle_q  <= '0;
      pad_q   <= 6'b111111;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      phase_q <= phase_d;
      idle_q  <= idle_d;
      pad_q   <= pad_d;
    end
  end

  assign bus.oPAD   = pad_q;
  assign bus.oPHASE = phase_q;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Self-checking bench for genesis_pad_responder: a table of SELECT/button/mode vectors
// with hand-computed pad and phase values, plus directed reset, latency and timeout cases.
module tb_genesis_pad_responder;

  localparam int unsigned Tmo = 100;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  genesis_pad_responder_if bus ();

  genesis_pad_responder #(
    .TIMEOUT(Tmo)
  ) dut (
    .iCLK    (clk),
    .iN_RESET(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        six;
    logic [11:0] btn;
    logic [5:0]  pad;
    logic [2:0]  ph;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] pad_exp, input logic [2:0] ph_exp);
    n_vec++;
    if (bus.oPAD !== pad_exp || bus.oPHASE !== ph_exp) begin
      n_bad++;
      $display("FAIL %s: got pad=%b phase=%0d, expected pad=%b phase=%0d",
               name, bus.oPAD, bus.oPHASE, pad_exp, ph_exp);
    end
  endtask

  task automatic sel_to(input logic s);
    bus.iSELECT = s;
    step(3);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Walk 0..7 twice in 6-button mode (plain, then Z|M), then a mixed pattern, then 3-button.
    tbl.push_back('{1'b1, 1'b1, 12'h000, 6'b111111, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 12'h000, 6'b111100, 3'd1});
    tbl.push_back('{1'b1, 1'b1, 12'h000, 6'b111111, 3'd2});
    tbl.push_back('{1'b0, 1'b1, 12'h000, 6'b111100, 3'd3});
    tbl.push_back('{1'b1, 1'b1, 12'h000, 6'b111111, 3'd4});
    tbl.push_back('{1'b0, 1'b1, 12'h000, 6'b110000, 3'd5});
    tbl.push_back('{1'b1, 1'b1, 12'h000, 6'b111111, 3'd6});
    tbl.push_back('{1'b0, 1'b1, 12'h000, 6'b111111, 3'd7});
    tbl.push_back('{1'b1, 1'b1, 12'h900, 6'b111111, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 12'h900, 6'b111100, 3'd1});
    tbl.push_back('{1'b1, 1'b1, 12'h900, 6'b111111, 3'd2});
    tbl.push_back('{1'b0, 1'b1, 12'h900, 6'b111100, 3'd3});
    tbl.push_back('{1'b1, 1'b1, 12'h900, 6'b111111, 3'd4});
    tbl.push_back('{1'b0, 1'b1, 12'h900, 6'b110000, 3'd5});
    tbl.push_back('{1'b1, 1'b1, 12'h900, 6'b110110, 3'd6});
    tbl.push_back('{1'b0, 1'b1, 12'h900, 6'b111111, 3'd7});
    tbl.push_back('{1'b1, 1'b1, 12'h900, 6'b111111, 3'd0});
    tbl.push_back('{1'b0, 1'b1, 12'hA95, 6'b001000, 3'd1});
    tbl.push_back('{1'b1, 1'b1, 12'hA95, 6'b111010, 3'd2});
    tbl.push_back('{1'b0, 1'b1, 12'hA95, 6'b001000, 3'd3});
    tbl.push_back('{1'b1, 1'b1, 12'hA95, 6'b111010, 3'd4});
    tbl.push_back('{1'b0, 1'b1, 12'hA95, 6'b000000, 3'd5});
    tbl.push_back('{1'b1, 1'b1, 12'hA95, 6'b110101, 3'd6});
    tbl.push_back('{1'b0, 1'b1, 12'hA95, 6'b001111, 3'd7});
    tbl.push_back('{1'b1, 1'b1, 12'hA95, 6'b111010, 3'd0});
    tbl.push_back('{1'b0, 1'b0, 12'h048, 6'b110100, 3'd1});
    tbl.push_back('{1'b1, 1'b0, 12'h048, 6'b010111, 3'd2});
    tbl.push_back('{1'b0, 1'b0, 12'h048, 6'b110100, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 12'h048, 6'b010111, 3'd4});
    tbl.push_back('{1'b0, 1'b0, 12'h048, 6'b110100, 3'd5});
    tbl.push_back('{1'b1, 1'b0, 12'h048, 6'b010111, 3'd6});
    tbl.push_back('{1'b0, 1'b0, 12'h040, 6'b111100, 3'd7});
    tbl.push_back('{1'b1, 1'b0, 12'h040, 6'b011111, 3'd0});

    // Reset holds the lines released even with every button pressed.
    rst_n           = 1'b0;
    bus.iSELECT     = 1'b1;
    bus.iSIX_BUTTON = 1'b1;
    bus.iBUTTONS    = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("reset_hold", 6'b111111, 3'd0);
    end
    rst_n = 1'b1;
    step(2);
    chk("reset_release", 6'b000000, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.iSELECT     = tbl[i].sel;
      bus.iSIX_BUTTON = tbl[i].six;
      bus.iBUTTONS    = tbl[i].btn;
      step(3);
      chk($sformatf("table[%0d]", i), tbl[i].pad, tbl[i].ph);
    end

    // SELECT latency is exactly three edges; buttons take one.
    bus.iSELECT = 1'b0;
    step(2);
    chk("sel_lat_2", 6'b011111, 3'd0);
    step(1);
    chk("sel_lat_3", 6'b111100, 3'd1);
    bus.iBUTTONS = 12'h048;
    step(1);
    chk("btn_lat_1", 6'b110100, 3'd1);
    sel_to(1'b1);
    chk("sel_high_3b", 6'b010111, 3'd2);

    // Timeout while SELECT is high returns to phase 0.
    rst_n           = 1'b0;
    bus.iSELECT     = 1'b1;
    bus.iSIX_BUTTON = 1'b1;
    bus.iBUTTONS    = 12'h000;
    step(2);
    rst_n = 1'b1;
    step(1);
    sel_to(1'b0);
    sel_to(1'b1);
    sel_to(1'b0);
    sel_to(1'b1);
    chk("tmo_pre", 6'b111111, 3'd4);
    step(Tmo);
    chk("tmo_hold", 6'b111111, 3'd4);
    step(1);
    chk("tmo_fire_hi", 6'b111111, 3'd0);
    sel_to(1'b0);
    chk("tmo_restart", 6'b111100, 3'd1);

    // Edge detected in the very cycle the idle counter reaches TIMEOUT wins.
    step(Tmo - 2);
    bus.iSELECT = 1'b1;
    step(2);
    chk("tmo_edge_pre", 6'b111100, 3'd1);
    step(1);
    chk("tmo_edge_win", 6'b111111, 3'd2);

    // Timeout while SELECT is low returns to phase 1.
    sel_to(1'b0);
    chk("tmo_lo_pre", 6'b111100, 3'd3);
    step(Tmo);
    chk("tmo_lo_hold", 6'b111100, 3'd3);
    step(1);
    chk("tmo_fire_lo", 6'b111100, 3'd1);

    // Reset in the middle of a 6-button sequence.
    rst_n        = 1'b0;
    bus.iSELECT  = 1'b1;
    bus.iBUTTONS = 12'hA95;
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) sel_to(i[0] ? 1'b1 : 1'b0);
    chk("mid_p5", 6'b000000, 3'd5);
    rst_n       = 1'b0;
    bus.iSELECT = 1'b1;
    step(1);
    chk("mid_reset", 6'b111111, 3'd0);
    rst_n = 1'b1;
    step(2);
    chk("mid_release", 6'b111010, 3'd0);
    sel_to(1'b0);
    chk("mid_first_fall", 6'b001000, 3'd1);

    // Dropping to 3-button mode at phase 5 replaces the ID pattern next cycle.
    for (int i = 0; i < 4; i++) sel_to(i[0] ? 1'b0 : 1'b1);
    chk("mode_p5_six", 6'b000000, 3'd5);
    bus.iSIX_BUTTON = 1'b0;
    step(1);
    chk("mode_p5_three", 6'b001000, 3'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
